// File: rtl/serial_divisibility_by_n.sv
// Serial divisibility checker: tracks (number received so far) mod N, one bit per
// accepted cycle, MSB-first or LSB-first, with a start-of-number marker.
module serial_divisibility_by_n #(
    parameter int N         = 5,
    parameter bit LSB_FIRST = 1'b0,
    localparam int W        = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bit_valid,
    input  logic         new_bit,
    input  logic         start,
    output logic [W-1:0] remainder,
    output logic         div_by_n,
    output logic         bit_seen
);

    localparam logic [W:0]   N_EXT     = (W+1)'(N);
    localparam logic [W-1:0] ONE       = W'(1);
    localparam logic [W-1:0] TWO_MOD_N = W'(2 % N);

    logic [W-1:0] r;
    logic [W-1:0] p;
    logic [W-1:0] r_next;
    logic [W-1:0] p_next;
    logic [W:0]   t;
    logic [W:0]   t_sub;
    logic [W:0]   s;
    logic [W:0]   s_sub;
    logic [W:0]   u;
    logic [W:0]   u_sub;

    // All intermediate sums stay below 2N, so one conditional subtract reduces them.
    always_comb begin
        t      = {r, new_bit};
        t_sub  = t - N_EXT;
        s      = {1'b0, r} + (new_bit ? {1'b0, p} : '0);
        s_sub  = s - N_EXT;
        u      = {p, 1'b0};
        u_sub  = u - N_EXT;
        r_next = r;
        p_next = p;
        if (start) begin
            r_next = {{(W-1){1'b0}}, new_bit};
            p_next = TWO_MOD_N;
        end else if (LSB_FIRST) begin
            r_next = (s >= N_EXT) ? s_sub[W-1:0] : s[W-1:0];
            p_next = (u >= N_EXT) ? u_sub[W-1:0] : u[W-1:0];
        end else begin
            r_next = (t >= N_EXT) ? t_sub[W-1:0] : t[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r        <= '0;
            p        <= ONE;
            div_by_n <= 1'b1;
            bit_seen <= 1'b0;
        end else if (bit_valid) begin
            r        <= r_next;
            p        <= p_next;
            div_by_n <= (r_next == '0);
            bit_seen <= 1'b1;
        end
    end

    assign remainder = r;

endmodule
